// File: rtl/dpram_tester_pkg.sv
// Shared types for the dual-port RAM pattern tester.
package dpram_tester_pkg;

   localparam int unsigned STATE_W = 3;

   // Test sequence: write/read/drain for pass 0, then again for pass 1.
   typedef enum logic [STATE_W-1:0] {
      IDLE = 3'd0,
      W0   = 3'd1,
      R0   = 3'd2,
      D0   = 3'd3,
      W1   = 3'd4,
      R1   = 3'd5,
      D1   = 3'd6,
      FIN  = 3'd7
   } state_t;

   // Pass encoding reported through FIRST_ERR_PASS.
   localparam logic PASS0 = 1'b0;
   localparam logic PASS1 = 1'b1;

endpackage

// File: rtl/dpram_tester_checker.sv
// Read-data checker: expected-data pipeline, compare, saturating error count
// and first-error capture.
module dpram_tester_checker
   import dpram_tester_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned ERR_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  rd_issue,
   input  logic                  rd_pass,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_exp,
   input  logic [DATA_WIDTH-1:0] do_a,
   input  logic                  do_valid_a,
   input  logic [DATA_WIDTH-1:0] do_b,
   input  logic                  do_valid_b,
   output logic [ERR_WIDTH-1:0]  err_count,
   output logic                  first_err_valid,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output logic                  first_err_pass
);

   logic                  pend_q;
   logic [DATA_WIDTH-1:0] exp_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  pass_q;
   logic [DATA_WIDTH-1:0] rd_data_c;
   logic                  rd_valid_c;
   logic                  mismatch_c;

   // Delay the expected word by the RAM read latency; reset drops any read in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= 1'b0;
         exp_q  <= '0;
         addr_q <= '0;
         pass_q <= PASS0;
      end else begin
         pend_q <= rd_issue & ~clr;
         exp_q  <= rd_exp;
         addr_q <= rd_addr;
         pass_q <= rd_pass;
      end
   end

   // Pass 1 reads on port A, pass 0 on port B; only valid data is compared.
   always_comb begin
      rd_data_c  = do_b;
      rd_valid_c = do_valid_b;
      if (pass_q == PASS1) begin
         rd_data_c  = do_a;
         rd_valid_c = do_valid_a;
      end
      mismatch_c = pend_q & rd_valid_c & (rd_data_c != exp_q);
   end

   // Count mismatches (saturating) and keep the first one of the run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_addr  <= '0;
         first_err_pass  <= PASS0;
      end else if (clr) begin
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_addr  <= '0;
         first_err_pass  <= PASS0;
      end else if (mismatch_c) begin
         if (err_count != {ERR_WIDTH{1'b1}}) begin
            err_count <= err_count + ERR_WIDTH'(1);
         end
         if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= addr_q;
            first_err_pass  <= pass_q;
         end
      end
   end

endmodule

// File: rtl/dpram_pattern_tester.sv
// Dual-port RAM pattern tester: writes seed+i on A, reads on B, writes the
// complement on B, reads on A, and reports mismatches.
module dpram_pattern_tester
   import dpram_tester_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned ERR_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [DATA_WIDTH-1:0] SEED,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [ERR_WIDTH-1:0]  ERR_COUNT,
   output logic                  FIRST_ERR_VALID,
   output logic [ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
   output logic                  FIRST_ERR_PASS,
   output logic [ADDR_WIDTH-1:0] ADDR_A,
   output logic [DATA_WIDTH-1:0] DI_A,
   output logic                  WE_A,
   output logic                  RE_A,
   output logic                  EN_A,
   input  logic [DATA_WIDTH-1:0] DO_A,
   input  logic                  DO_VALID_A,
   output logic [ADDR_WIDTH-1:0] ADDR_B,
   output logic [DATA_WIDTH-1:0] DI_B,
   output logic                  WE_B,
   output logic                  RE_B,
   output logic                  EN_B,
   input  logic [DATA_WIDTH-1:0] DO_B,
   input  logic                  DO_VALID_B
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] seed_q, seed_d;
   logic                  accept;
   logic [DATA_WIDTH-1:0] pat_d;
   logic [ADDR_WIDTH-1:0] addr_a_d, addr_b_d;
   logic [DATA_WIDTH-1:0] di_a_d, di_b_d;
   logic                  we_a_d, re_a_d, en_a_d, we_b_d, re_b_d, en_b_d;
   logic                  busy_d, done_d;
   logic                  rd_issue_c, rd_pass_c;
   logic [ADDR_WIDTH-1:0] rd_addr_c;
   logic [DATA_WIDTH-1:0] rd_pat_c, rd_exp_c;

   // Next state plus the RAM access for the cycle that state will occupy.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      seed_d   = seed_q;
      accept   = 1'b0;
      addr_a_d = '0;
      addr_b_d = '0;
      di_a_d   = '0;
      di_b_d   = '0;
      we_a_d   = 1'b0;
      re_a_d   = 1'b0;
      en_a_d   = 1'b0;
      we_b_d   = 1'b0;
      re_b_d   = 1'b0;
      en_b_d   = 1'b0;

      case (state_q)
         IDLE, FIN: begin
            if (START) begin
               accept  = 1'b1;
               state_d = W0;
               cnt_d   = '0;
               seed_d  = SEED;
            end
         end
         W0, R0, W1, R1: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) begin
               case (state_q)
                  W0:      state_d = R0;
                  R0:      state_d = D0;
                  W1:      state_d = R1;
                  default: state_d = D1;
               endcase
            end
         end
         D0:      state_d = W1;
         D1:      state_d = FIN;
         default: state_d = IDLE;
      endcase

      pat_d = seed_d + DATA_WIDTH'(cnt_d);

      case (state_d)
         W0: begin
            en_a_d   = 1'b1;
            we_a_d   = 1'b1;
            addr_a_d = cnt_d;
            di_a_d   = pat_d;
         end
         R0: begin
            en_b_d   = 1'b1;
            re_b_d   = 1'b1;
            addr_b_d = cnt_d;
         end
         W1: begin
            en_b_d   = 1'b1;
            we_b_d   = 1'b1;
            addr_b_d = cnt_d;
            di_b_d   = ~pat_d;
         end
         R1: begin
            en_a_d   = 1'b1;
            re_a_d   = 1'b1;
            addr_a_d = cnt_d;
         end
         default: ;
      endcase

      busy_d = (state_d != IDLE) && (state_d != FIN);
      done_d = (state_d == FIN);
   end

   // State, counter, seed and all registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         seed_q  <= '0;
         ADDR_A  <= '0;
         DI_A    <= '0;
         WE_A    <= 1'b0;
         RE_A    <= 1'b0;
         EN_A    <= 1'b0;
         ADDR_B  <= '0;
         DI_B    <= '0;
         WE_B    <= 1'b0;
         RE_B    <= 1'b0;
         EN_B    <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         seed_q  <= seed_d;
         ADDR_A  <= addr_a_d;
         DI_A    <= di_a_d;
         WE_A    <= we_a_d;
         RE_A    <= re_a_d;
         EN_A    <= en_a_d;
         ADDR_B  <= addr_b_d;
         DI_B    <= di_b_d;
         WE_B    <= we_b_d;
         RE_B    <= re_b_d;
         EN_B    <= en_b_d;
         BUSY    <= busy_d;
         DONE    <= done_d;
      end
   end

   // Expected word for the read currently on the RAM ports.
   always_comb begin
      rd_issue_c = (EN_A & RE_A) | (EN_B & RE_B);
      rd_pass_c  = (EN_A & RE_A) ? PASS1 : PASS0;
      rd_addr_c  = (rd_pass_c == PASS1) ? ADDR_A : ADDR_B;
      rd_pat_c   = seed_q + DATA_WIDTH'(rd_addr_c);
      rd_exp_c   = (rd_pass_c == PASS1) ? ~rd_pat_c : rd_pat_c;
   end

   dpram_tester_checker #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ERR_WIDTH  (ERR_WIDTH)
   ) u_checker (
      .clk             (CLK),
      .rst             (RST),
      .clr             (accept),
      .rd_issue        (rd_issue_c),
      .rd_pass         (rd_pass_c),
      .rd_addr         (rd_addr_c),
      .rd_exp          (rd_exp_c),
      .do_a            (DO_A),
      .do_valid_a      (DO_VALID_A),
      .do_b            (DO_B),
      .do_valid_b      (DO_VALID_B),
      .err_count       (ERR_COUNT),
      .first_err_valid (FIRST_ERR_VALID),
      .first_err_addr  (FIRST_ERR_ADDR),
      .first_err_pass  (FIRST_ERR_PASS)
   );

endmodule

// File: tb/tb_dpram_pattern_tester.sv
// Bench for dpram_pattern_tester with a one-cycle true dual-port RAM model.
module tb_dpram_pattern_tester;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned EW    = 4;
   localparam int          DEPTH = 16;
   localparam int          EMAX  = 15;

   logic          CLK, RST, START;
   logic [DW-1:0] SEED;
   logic          BUSY, DONE, FIRST_ERR_VALID, FIRST_ERR_PASS;
   logic [EW-1:0] ERR_COUNT;
   logic [AW-1:0] FIRST_ERR_ADDR, ADDR_A, ADDR_B;
   logic [DW-1:0] DI_A, DI_B, DO_A, DO_B;
   logic          WE_A, RE_A, EN_A, WE_B, RE_B, EN_B, DO_VALID_A, DO_VALID_B;

   dpram_pattern_tester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_WIDTH(EW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .SEED(SEED),
      .BUSY(BUSY), .DONE(DONE), .ERR_COUNT(ERR_COUNT),
      .FIRST_ERR_VALID(FIRST_ERR_VALID), .FIRST_ERR_ADDR(FIRST_ERR_ADDR),
      .FIRST_ERR_PASS(FIRST_ERR_PASS),
      .ADDR_A(ADDR_A), .DI_A(DI_A), .WE_A(WE_A), .RE_A(RE_A), .EN_A(EN_A),
      .DO_A(DO_A), .DO_VALID_A(DO_VALID_A),
      .ADDR_B(ADDR_B), .DI_B(DI_B), .WE_B(WE_B), .RE_B(RE_B), .EN_B(EN_B),
      .DO_B(DO_B), .DO_VALID_B(DO_VALID_B)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // RAM model; mode 1 flips bit 0 of port-B data for fault_addr, mode 2 zeroes all read data.
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] ram_do_a, ram_do_b;
   logic [AW-1:0] rd_addr_b_q;
   int            fault_mode, fault_addr;

   always @(posedge CLK) begin
      if (EN_A && WE_A) mem[ADDR_A] <= DI_A;
      if (EN_B && WE_B) mem[ADDR_B] <= DI_B;
      if (EN_A && RE_A) ram_do_a <= mem[ADDR_A];
      if (EN_B && RE_B) begin
         ram_do_b    <= mem[ADDR_B];
         rd_addr_b_q <= ADDR_B;
      end
      DO_VALID_A <= EN_A && RE_A;
      DO_VALID_B <= EN_B && RE_B;
   end

   assign DO_A = (fault_mode == 2) ? '0 : ram_do_a;
   assign DO_B = (fault_mode == 2) ? '0 :
                 (ram_do_b ^ {7'b0, (fault_mode == 1 && rd_addr_b_q == AW'(fault_addr))});

   typedef struct {
      bit            port;
      bit            we;
      bit            re;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } acc_t;

   acc_t obs_q[$];
   bit   recording;
   int   strobe_bad;
   int   total, bad;

   // Log every RAM access and flag any illegal strobe combination.
   always @(negedge CLK) begin
      if (recording) begin
         if (EN_A) obs_q.push_back('{1'b0, WE_A, RE_A, ADDR_A, DI_A});
         if (EN_B) obs_q.push_back('{1'b1, WE_B, RE_B, ADDR_B, DI_B});
         if ((!EN_A && (WE_A || RE_A)) || (!EN_B && (WE_B || RE_B)) ||
             (EN_A && EN_B) || (EN_A && (WE_A == RE_A)) || (EN_B && (WE_B == RE_B)))
            strobe_bad++;
      end
   end

   // Behavioural outcome of a whole run: write pattern, read it, write complement, read it.
   function automatic void ref_model(input logic [DW-1:0] seed, input int mode, input int fa,
                                     output int errs, output int faddr, output int fpass,
                                     output bit fvalid);
      logic [DW-1:0] m [DEPTH];
      logic [DW-1:0] wr, rd;
      errs = 0; faddr = 0; fpass = 0; fvalid = 0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < DEPTH; i++) begin
            wr   = seed + DW'(i);
            m[i] = (p == 1) ? ~wr : wr;
         end
         for (int i = 0; i < DEPTH; i++) begin
            rd = m[i];
            if (mode == 2) rd = '0;
            if (mode == 1 && p == 0 && i == fa) rd = rd ^ 8'h01;
            if (rd != m[i]) begin
               if (errs < EMAX) errs++;
               if (!fvalid) begin
                  fvalid = 1; faddr = i; fpass = p;
               end
            end
         end
      end
   endfunction

   // Start a run, optionally pulse START again at cycle pulse_at, wait for DONE, score the access trace.
   task automatic run_test(input logic [DW-1:0] seed, input int mode, input int fa,
                           input int pulse_at, output int done_cyc, output int trace_bad,
                           output bit cleared);
      acc_t          e;
      logic [DW-1:0] p;
      fault_mode = mode; fault_addr = fa;
      obs_q.delete(); strobe_bad = 0;
      done_cyc = -1; cleared = 0;
      @(posedge CLK); #1;
      START = 1'b1; SEED = seed; recording = 1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge CLK); #1;
         START = (n == pulse_at);
         SEED  = 8'($urandom);
         if (n == 1) cleared = (DONE === 1'b0) && (BUSY === 1'b1);
         if (DONE === 1'b1) begin
            done_cyc = n;
            break;
         end
      end
      START = 1'b0; recording = 0;
      trace_bad = (obs_q.size() != 4 * DEPTH) ? 1 : 0;
      for (int k = 0; k < obs_q.size() && k < 4 * DEPTH; k++) begin
         p      = seed + DW'(k % DEPTH);
         e.addr = AW'(k % DEPTH);
         case (k / DEPTH)
            0:       begin e.port = 0; e.we = 1; e.re = 0; e.data = p;  end
            1:       begin e.port = 1; e.we = 0; e.re = 1; e.data = '0; end
            2:       begin e.port = 1; e.we = 1; e.re = 0; e.data = ~p; end
            default: begin e.port = 0; e.we = 0; e.re = 1; e.data = '0; end
         endcase
         if (obs_q[k].port != e.port || obs_q[k].we != e.we || obs_q[k].re != e.re ||
             obs_q[k].addr !== e.addr || (e.we && obs_q[k].data !== e.data))
            trace_bad++;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; START = 1'b0; SEED = '0; fault_mode = 0; fault_addr = 0;
      repeat (3) @(posedge CLK);
      #1;
      total++;
      if ({EN_A, WE_A, RE_A, EN_B, WE_B, RE_B} !== 6'b0) begin
         bad++; $display("FAIL reset_strobes: got %b want 000000", {EN_A, WE_A, RE_A, EN_B, WE_B, RE_B});
      end
      total++;
      if ({BUSY, DONE, FIRST_ERR_VALID, FIRST_ERR_PASS} !== 4'b0 || ERR_COUNT !== '0 || FIRST_ERR_ADDR !== '0) begin
         bad++; $display("FAIL reset_status: busy=%b done=%b err=%0d fev=%b want all 0", BUSY, DONE, ERR_COUNT, FIRST_ERR_VALID);
      end
      total++;
      if (ADDR_A !== '0 || ADDR_B !== '0 || DI_A !== '0 || DI_B !== '0) begin
         bad++; $display("FAIL reset_bus: addr_a=%h addr_b=%h di_a=%h di_b=%h want 0", ADDR_A, ADDR_B, DI_A, DI_B);
      end
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      total++;
      if (BUSY !== 1'b0 || DONE !== 1'b0) begin
         bad++; $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", BUSY, DONE);
      end
   endtask

   task automatic test_clean();
      logic [DW-1:0] seed;
      int dc, tb_, errs, fa, fp;
      bit cl, fv;
      for (int r = 0; r < 4; r++) begin
         seed = (r == 0) ? 8'h10 : 8'($urandom);
         run_test(seed, 0, 0, 0, dc, tb_, cl);
         ref_model(seed, 0, 0, errs, fa, fp, fv);
         total++;
         if (dc !== 67) begin
            bad++; $display("FAIL clean_done_latency seed=%h: got %0d want 67", seed, dc);
         end
         total++;
         if (tb_ !== 0 || strobe_bad !== 0) begin
            bad++; $display("FAIL clean_trace seed=%h: trace errors %0d strobe errors %0d want 0 0", seed, tb_, strobe_bad);
         end
         total++;
         if (ERR_COUNT !== EW'(errs) || FIRST_ERR_VALID !== fv || BUSY !== 1'b0) begin
            bad++; $display("FAIL clean_result seed=%h: err=%0d fev=%b busy=%b want %0d %b 0", seed, ERR_COUNT, FIRST_ERR_VALID, BUSY, errs, fv);
         end
         total++;
         if (!cl) begin
            bad++; $display("FAIL clean_start_clear seed=%h: DONE/BUSY after accept got %b want 1", seed, cl);
         end
      end
   endtask

   task automatic test_fault();
      logic [DW-1:0] seed;
      int dc, tb_, errs, fa, fp, inj;
      bit cl, fv;
      for (int r = 0; r < 3; r++) begin
         seed = (r == 0) ? 8'h10 : 8'($urandom);
         inj  = (r == 0) ? 5 : int'($urandom_range(0, DEPTH - 1));
         run_test(seed, 1, inj, 0, dc, tb_, cl);
         ref_model(seed, 1, inj, errs, fa, fp, fv);
         total++;
         if (ERR_COUNT !== EW'(errs) || FIRST_ERR_VALID !== fv) begin
            bad++; $display("FAIL fault_count addr=%0d: got %0d/%b want %0d/%b", inj, ERR_COUNT, FIRST_ERR_VALID, errs, fv);
         end
         total++;
         if (FIRST_ERR_ADDR !== AW'(fa) || FIRST_ERR_PASS !== 1'(fp)) begin
            bad++; $display("FAIL fault_first addr=%0d: got addr %0d pass %b want %0d %0d", inj, FIRST_ERR_ADDR, FIRST_ERR_PASS, fa, fp);
         end
      end
      // Results must stay put while parked in FIN.
      repeat (5) @(posedge CLK);
      #1;
      total++;
      if (DONE !== 1'b1 || BUSY !== 1'b0 || ERR_COUNT !== EW'(errs) || FIRST_ERR_ADDR !== AW'(fa)) begin
         bad++; $display("FAIL fin_hold: done=%b busy=%b err=%0d addr=%0d want 1 0 %0d %0d", DONE, BUSY, ERR_COUNT, FIRST_ERR_ADDR, errs, fa);
      end
   endtask

   task automatic test_saturation();
      logic [DW-1:0] seed;
      int dc, tb_, errs, fa, fp;
      bit cl, fv;
      for (int r = 0; r < 2; r++) begin
         seed = (r == 0) ? 8'h01 : 8'($urandom);
         run_test(seed, 2, 0, 0, dc, tb_, cl);
         ref_model(seed, 2, 0, errs, fa, fp, fv);
         total++;
         if (ERR_COUNT !== EW'(errs)) begin
            bad++; $display("FAIL sat_count seed=%h: got %0d want %0d", seed, ERR_COUNT, errs);
         end
         total++;
         if (FIRST_ERR_VALID !== fv || FIRST_ERR_ADDR !== AW'(fa) || FIRST_ERR_PASS !== 1'(fp)) begin
            bad++; $display("FAIL sat_first seed=%h: got %b/%0d/%b want %b/%0d/%0d", seed, FIRST_ERR_VALID, FIRST_ERR_ADDR, FIRST_ERR_PASS, fv, fa, fp);
         end
      end
   endtask

   task automatic test_busy_start();
      int dc, tb_, errs, fa, fp;
      bit cl, fv;
      run_test(8'h10, 0, 0, 25, dc, tb_, cl);
      ref_model(8'h10, 0, 0, errs, fa, fp, fv);
      total++;
      if (dc !== 67 || tb_ !== 0 || strobe_bad !== 0) begin
         bad++; $display("FAIL busy_start_run: done at %0d trace errors %0d want 67 0", dc, tb_);
      end
      total++;
      if (ERR_COUNT !== EW'(errs) || FIRST_ERR_VALID !== fv) begin
         bad++; $display("FAIL busy_start_result: err=%0d fev=%b want %0d %b", ERR_COUNT, FIRST_ERR_VALID, errs, fv);
      end
   endtask

   task automatic test_reset_mid();
      int dc, tb_, errs, fa, fp;
      bit cl, fv;
      fault_mode = 0;
      @(posedge CLK); #1;
      START = 1'b1; SEED = 8'h3C;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (40) @(posedge CLK);
      #1;
      total++;
      if (EN_B !== 1'b1 || WE_B !== 1'b1 || ADDR_B !== AW'(7)) begin
         bad++; $display("FAIL mid_position: en_b=%b we_b=%b addr_b=%0d want 1 1 7", EN_B, WE_B, ADDR_B);
      end
      RST = 1'b1;
      #1;
      total++;
      if ({EN_A, WE_A, RE_A, EN_B, WE_B, RE_B} !== 6'b0) begin
         bad++; $display("FAIL mid_reset_strobes: got %b want 000000", {EN_A, WE_A, RE_A, EN_B, WE_B, RE_B});
      end
      total++;
      if (BUSY !== 1'b0 || DONE !== 1'b0 || ERR_COUNT !== '0 || ADDR_B !== '0 || DI_B !== '0) begin
         bad++; $display("FAIL mid_reset_outputs: busy=%b done=%b err=%0d addr_b=%0d di_b=%h want 0", BUSY, DONE, ERR_COUNT, ADDR_B, DI_B);
      end
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      total++;
      if (BUSY !== 1'b0 || DONE !== 1'b0 || EN_A !== 1'b0 || EN_B !== 1'b0) begin
         bad++; $display("FAIL mid_idle: busy=%b done=%b en=%b%b want 0 0 00", BUSY, DONE, EN_A, EN_B);
      end
      run_test(8'h3C, 0, 0, 0, dc, tb_, cl);
      ref_model(8'h3C, 0, 0, errs, fa, fp, fv);
      total++;
      if (dc !== 67 || tb_ !== 0 || ERR_COUNT !== EW'(errs) || FIRST_ERR_VALID !== fv) begin
         bad++; $display("FAIL mid_rerun: done at %0d trace %0d err %0d want 67 0 %0d", dc, tb_, ERR_COUNT, errs);
      end
   endtask

   initial begin
      total = 0; bad = 0; recording = 0; strobe_bad = 0;
      test_reset();
      test_clean();
      test_fault();
      test_saturation();
      test_busy_start();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
